// File: rtl/uart_dbg_pkg.sv
// Shared types and protocol constants for the UART debug responder.
package uart_dbg_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StLen,
      StWdata,
      StChk,
      StMemReq,
      StMemWait,
      StTxData,
      StTxResp
   } state_e;

   localparam logic [7:0] CmdWrite = 8'h57;
   localparam logic [7:0] CmdRead  = 8'h52;
   localparam logic [7:0] RespAck  = 8'h06;
   localparam logic [7:0] RespNak  = 8'h15;

   function automatic logic accepts_rx(state_e s);
      return s inside {StIdle, StAddr, StLen, StWdata, StChk};
   endfunction

endpackage

// File: rtl/uart_dbg_timeout.sv
// Inter-byte idle counter: expires after Cycles consecutive ticks without a load.
module uart_dbg_timeout #(
   parameter int unsigned Cycles = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic tick_i,
   output logic expired_o
);

   if (Cycles == 0) begin : g_off
      assign expired_o = 1'b0;
   end else begin : g_on
      localparam int unsigned W = (Cycles > 1) ? $clog2(Cycles) : 1;
      localparam logic [W-1:0] Last = W'(Cycles - 1);

      logic [W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (load_i) begin
            cnt_d = '0;
         end else if (tick_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + W'(1);
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign expired_o = tick_i && !load_i && (cnt_q == Last);
   end

endmodule

// File: rtl/uart_dbg_responder.sv
// Byte-stream debug responder: 'W'/'R' commands turned into 32-bit memory accesses.
// Optional trailing XOR checksum byte when UART_DBG_CHKSUM_EN is defined.
module uart_dbg_responder
   import uart_dbg_pkg::*;
#(
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned TimeoutCycles = 1000000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic [3:0]           mem_be_o,
   output logic [31:0]          mem_wdata_o,
   input  logic                 mem_rvalid_i,
   input  logic [31:0]          mem_rdata_i,
   input  logic                 mem_err_i,
   output logic                 busy_o
);

   localparam int unsigned AddrBytes    = AddrWidth / 8;
   localparam logic [7:0]  LastAddrByte = 8'(AddrBytes - 1);

`ifdef UART_DBG_CHKSUM_EN
   localparam state_e AfterLenRd  = StChk;
   localparam state_e AfterLastWr = StChk;
`else
   localparam state_e AfterLenRd  = StMemReq;
   localparam state_e AfterLastWr = StTxResp;
`endif

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
   logic [7:0]           byte_cnt_q, byte_cnt_d, len_q, len_d, tx_data_q, tx_data_d;
   logic                 is_write_q, is_write_d, err_q, err_d;
   logic                 in_rx_state, rx_fire, tick, load, expired;
`ifdef UART_DBG_CHKSUM_EN
   logic [7:0]           chk_q, chk_d;
`endif

   assign in_rx_state = accepts_rx(state_q);
   // Gated by reset so the host never sees ready while the block is held in reset.
   assign rx_ready_o  = rst_ni & in_rx_state;
   assign rx_fire     = rx_valid_i & rx_ready_o;
   assign tx_valid_o  = (state_q == StTxData) || (state_q == StTxResp);
   assign tx_data_o   = tx_data_q;
   assign mem_req_o   = (state_q == StMemReq);
   assign mem_we_o    = mem_req_o & is_write_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = 4'hF;
   assign busy_o      = (state_q != StIdle);

   assign tick = in_rx_state && (state_q != StIdle) && !rx_fire;
   assign load = !tick;

   uart_dbg_timeout #(
      .Cycles(TimeoutCycles)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (load),
      .tick_i   (tick),
      .expired_o(expired)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      tx_data_d  = tx_data_q;
      is_write_d = is_write_q;
      err_d      = err_q;

      unique case (state_q)
         StIdle: begin
            if (rx_fire) begin
               byte_cnt_d = '0;
               err_d      = 1'b0;
               if ((rx_data_i == CmdWrite) || (rx_data_i == CmdRead)) begin
                  is_write_d = (rx_data_i == CmdWrite);
                  state_d    = StAddr;
               end else begin
                  err_d   = 1'b1;
                  state_d = StTxResp;
               end
            end
         end
         StAddr: begin
            if (rx_fire) begin
               // Little-endian: shift in from the top so the first byte lands at [7:0].
               addr_d = {rx_data_i, addr_q[AddrWidth-1:8]};
               if (byte_cnt_q == LastAddrByte) begin
                  byte_cnt_d = '0;
                  state_d    = StLen;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         StLen: begin
            if (rx_fire) begin
               len_d   = rx_data_i;
               state_d = is_write_q ? StWdata : AfterLenRd;
            end
         end
         StWdata: begin
            if (rx_fire) begin
               wdata_d = {rx_data_i, wdata_q[31:8]};
               if (byte_cnt_q == 8'd3) begin
                  byte_cnt_d = '0;
                  state_d    = StMemReq;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         StChk: begin
`ifdef UART_DBG_CHKSUM_EN
            if (rx_fire) begin
               if (rx_data_i != chk_q) begin
                  err_d = 1'b1;
               end
               state_d = is_write_q ? StTxResp : StMemReq;
            end
`else
            state_d = StIdle;
`endif
         end
         StMemReq: begin
            if (mem_gnt_i) begin
               state_d = StMemWait;
            end
         end
         StMemWait: begin
            if (mem_rvalid_i) begin
               addr_d = addr_q + AddrWidth'(4);
               if (mem_err_i) begin
                  err_d = 1'b1;
               end
               if (is_write_q) begin
                  if (len_q == 8'd0) begin
                     state_d = AfterLastWr;
                  end else begin
                     len_d   = len_q - 8'd1;
                     state_d = StWdata;
                  end
               end else begin
                  rdata_d    = mem_err_i ? 32'h0 : mem_rdata_i;
                  tx_data_d  = mem_err_i ? 8'h00 : mem_rdata_i[7:0];
                  byte_cnt_d = '0;
                  state_d    = StTxData;
               end
            end
         end
         StTxData: begin
            if (tx_ready_i) begin
               if (byte_cnt_q == 8'd3) begin
                  byte_cnt_d = '0;
                  if (len_q == 8'd0) begin
                     state_d = StTxResp;
                  end else begin
                     len_d   = len_q - 8'd1;
                     state_d = StMemReq;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
                  rdata_d    = rdata_q >> 8;
                  tx_data_d  = rdata_q[15:8];
               end
            end
         end
         StTxResp: begin
            if (tx_ready_i) begin
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (expired) begin
         state_d = StIdle;
      end

      // Reply byte is latched on entry so it stays stable while stalled.
      if ((state_d == StTxResp) && (state_q != StTxResp)) begin
         tx_data_d = err_d ? RespNak : RespAck;
      end
   end

`ifdef UART_DBG_CHKSUM_EN
   always_comb begin
      chk_d = chk_q;
      if (state_q == StIdle) begin
         chk_d = 8'h00;
      end else if (rx_fire && (state_q != StChk)) begin
         chk_d = chk_q ^ rx_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chk_q <= 8'h00;
      end else begin
         chk_q <= chk_d;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         byte_cnt_q <= '0;
         len_q      <= '0;
         tx_data_q  <= '0;
         is_write_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         tx_data_q  <= tx_data_d;
         is_write_q <= is_write_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Directed bench for uart_dbg_responder: command vector table plus reset/timeout sequences.
module tb_uart_dbg_responder;

   localparam int unsigned AW = 64;

   logic          clk, rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid, rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid, tx_ready;
   logic          mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, busy;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]    tx_q[$];
   logic [AW-1:0] req_addr_q[$];
   logic          req_we_q[$];
   logic [31:0]   req_wdata_q[$];
   logic [31:0]   cur_rdata = 32'h0;
   logic          cur_err   = 1'b0;

   uart_dbg_responder #(
      .AddrWidth    (AW),
      .TimeoutCycles(16)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .rx_ready_o  (rx_ready),
      .tx_data_o   (tx_data),
      .tx_valid_o  (tx_valid),
      .tx_ready_i  (tx_ready),
      .mem_req_o   (mem_req),
      .mem_gnt_i   (mem_gnt),
      .mem_addr_o  (mem_addr),
      .mem_we_o    (mem_we),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i (mem_rdata),
      .mem_err_i   (mem_err),
      .busy_o      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   typedef struct {
      string             name;
      logic [7:0]        cmd;
      logic [63:0]       addr;
      logic [7:0]        len;
      logic [1:0][31:0]  wdata;
      logic [31:0]       rdata;
      logic              err;
      int                n_tx;
      logic [0:9][7:0]   tx;
      int                n_req;
      logic [1:0][63:0]  req_addr;
      logic [1:0][31:0]  req_wdata;
   } vec_t;

   function automatic vec_t mk(string name, logic [7:0] cmd, logic [63:0] addr, logic [7:0] len,
                               logic [63:0] wdata, logic [31:0] rdata, logic err, int n_tx,
                               logic [79:0] tx, int n_req, logic [127:0] req_addr,
                               logic [63:0] req_wdata);
      vec_t v;
      v.name = name;   v.cmd = cmd;     v.addr = addr;   v.len = len;
      v.wdata = wdata; v.rdata = rdata; v.err = err;     v.n_tx = n_tx;
      v.tx = tx;       v.n_req = n_req; v.req_addr = req_addr; v.req_wdata = req_wdata;
      return v;
   endfunction

   // Memory: grant one cycle after request, respond the cycle after grant.
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_gnt) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = cur_rdata;
            mem_err    = cur_err;
         end else begin
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            if (mem_req) begin
               mem_gnt = 1'b1;
               req_addr_q.push_back(mem_addr);
               req_we_q.push_back(mem_we);
               req_wdata_q.push_back(mem_wdata);
               chk("mem_be", mem_be, 4'hF);
            end
         end
      end
   end

   // TX sink with random backpressure; a stalled byte must hold until taken.
   initial begin
      logic       pend;
      logic [7:0] pend_data;
      pend = 1'b0; pend_data = 8'h00; tx_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("tx_valid hold", tx_valid, 1'b1);
            chk("tx_data hold", tx_data, pend_data);
         end
         tx_ready = ($urandom_range(0, 3) != 0);
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         pend      = tx_valid && !tx_ready;
         pend_data = tx_data;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ready for byte", rx_ready, 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({name, " back to idle"}, busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic clear_logs();
      tx_q.delete(); req_addr_q.delete(); req_we_q.delete(); req_wdata_q.delete();
   endtask

   task automatic run_vec(input vec_t v, input bit bad_chk);
      logic [7:0] bytes[$];
      logic [7:0] csum = 8'h00;
      clear_logs();
      cur_rdata = v.rdata;
      cur_err   = v.err;
      bytes.push_back(v.cmd);
      if (v.cmd == 8'h57 || v.cmd == 8'h52) begin
         for (int i = 0; i < 8; i++) bytes.push_back(v.addr[8*i +: 8]);
         bytes.push_back(v.len);
         if (v.cmd == 8'h57) begin
            for (int w = 0; w <= int'(v.len); w++) begin
               for (int i = 0; i < 4; i++) bytes.push_back(v.wdata[w][8*i +: 8]);
            end
         end
         for (int i = 1; i < bytes.size(); i++) csum ^= bytes[i];
`ifdef UART_DBG_CHKSUM_EN
         bytes.push_back(bad_chk ? ~csum : csum);
`endif
      end
      foreach (bytes[i]) send_byte(bytes[i]);
      wait_idle(v.name);
      chk({v.name, " tx count"}, tx_q.size(), v.n_tx);
      for (int i = 0; i < v.n_tx && i < tx_q.size(); i++) begin
         chk($sformatf("%s tx[%0d]", v.name, i), tx_q[i], v.tx[i]);
      end
      chk({v.name, " req count"}, req_addr_q.size(), v.n_req);
      for (int i = 0; i < v.n_req && i < req_addr_q.size(); i++) begin
         chk($sformatf("%s req_addr[%0d]", v.name, i), req_addr_q[i], v.req_addr[i]);
         chk($sformatf("%s req_we[%0d]", v.name, i), req_we_q[i], v.cmd == 8'h57);
         if (v.cmd == 8'h57)
            chk($sformatf("%s req_wdata[%0d]", v.name, i), req_wdata_q[i], v.req_wdata[i]);
      end
   endtask

   initial begin
      vec_t vecs[7];
      vec_t v;
      int   n;

      vecs[0] = mk("wr2", 8'h57, 64'h10000000, 8'h01, {32'h88776655, 32'h44332211}, 32'h0, 1'b0,
                   1, {8'h06, 72'h0}, 2, {64'h10000004, 64'h10000000},
                   {32'h88776655, 32'h44332211});
      vecs[1] = mk("rd1", 8'h52, 64'h10000000, 8'h00, 64'h0, 32'hDEADBEEF, 1'b0,
                   5, {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06, 40'h0}, 1, {64'h0, 64'h10000000}, 64'h0);
      vecs[2] = mk("badcmd", 8'h41, 64'h0, 8'h00, 64'h0, 32'h0, 1'b0,
                   1, {8'h15, 72'h0}, 0, 128'h0, 64'h0);
      vecs[3] = mk("rderr", 8'h52, 64'h10000000, 8'h00, 64'h0, 32'hDEADBEEF, 1'b1,
                   5, {8'h00, 8'h00, 8'h00, 8'h00, 8'h15, 40'h0}, 1, {64'h0, 64'h10000000}, 64'h0);
      vecs[4] = mk("rdwrap", 8'h52, 64'hFFFFFFFFFFFFFFFC, 8'h01, 64'h0, 32'h12345678, 1'b0,
                   9, {8'h78, 8'h56, 8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12, 8'h06, 8'h00},
                   2, {64'h0, 64'hFFFFFFFFFFFFFFFC}, 64'h0);
      vecs[5] = mk("wrerr", 8'h57, 64'h20, 8'h00, {32'h0, 32'hDDCCBBAA}, 32'h0, 1'b1,
                   1, {8'h15, 72'h0}, 1, {64'h0, 64'h20}, {32'h0, 32'hDDCCBBAA});
      vecs[6] = mk("wrok", 8'h57, 64'h8, 8'h00, {32'h0, 32'h04030201}, 32'h0, 1'b0,
                   1, {8'h06, 72'h0}, 1, {64'h0, 64'h8}, {32'h0, 32'h04030201});

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset rx_ready", rx_ready, 1'b0);
      chk("reset tx_valid", tx_valid, 1'b0);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset mem_req", mem_req, 1'b0);
      chk("reset mem_we", mem_we, 1'b0);
      chk("reset mem_addr", mem_addr, 64'h0);
      chk("reset mem_wdata", mem_wdata, 32'h0);
      chk("reset mem_be", mem_be, 4'hF);
      chk("reset busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rx_ready after reset", rx_ready, 1'b1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

      // Reset in the middle of a command abandons it silently.
      clear_logs();
      send_byte(8'h57);
      send_byte(8'h00);
      chk("mid-cmd busy", busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 1'b0);
      chk("abort rx_ready", rx_ready, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort tx count", tx_q.size(), 0);
      run_vec(vecs[6], 1'b0);

      // Silence mid-command returns to idle after exactly 16 idle cycles.
      clear_logs();
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("timeout cycles", n, 16);
      chk("timeout busy", busy, 1'b0);
      repeat (4) @(negedge clk);
      chk("timeout tx count", tx_q.size(), 0);
      chk("timeout req count", req_addr_q.size(), 0);
      run_vec(vecs[1], 1'b0);

`ifdef UART_DBG_CHKSUM_EN
      v = vecs[6];
      v.name = "chkbad";
      v.tx   = {8'h15, 72'h0};
      run_vec(v, 1'b1);
      v.name = "chkgood";
      v.tx   = {8'h06, 72'h0};
      run_vec(v, 1'b0);
`else
      v = vecs[0];
      run_vec(v, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
